regfile_cmd_sequencer: RTL and testbench

//  Command-driven initiator for the 4xR / 4xT 8-bit register file (RSel/TSel/FunSel/O1Sel/O2Sel port set).

---
 rtl/regfile_cmd_sequencer_if.sv | 35 +++
 rtl/regfile_cmd_sequencer.sv | 154 +++++++++++++++
 tb/tb_regfile_cmd_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_cmd_sequencer_if.sv
// Command/response handshake plus register-file control bus between the
// control unit (master) and the register-transfer sequencer (slave).
interface regfile_cmd_sequencer_if #(
   parameter int WIDTH = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [2:0]       cmd_dst;
   logic [2:0]       cmd_src;
   logic [WIDTH-1:0] cmd_imm;
   logic             busy;
   logic             rsp_valid;
   logic [WIDTH-1:0] rsp_data;
   logic [WIDTH-1:0] rf_I;
   logic [1:0]       rf_FunSel;
   logic [3:0]       rf_RSel;
   logic [3:0]       rf_TSel;
   logic [2:0]       rf_O1Sel;
   logic [2:0]       rf_O2Sel;
   logic [WIDTH-1:0] rf_O1;
   logic [WIDTH-1:0] rf_O2;

   modport master (
      output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, rf_O1, rf_O2,
      input  cmd_ready, busy, rsp_valid, rsp_data,
      input  rf_I, rf_FunSel, rf_RSel, rf_TSel, rf_O1Sel, rf_O2Sel
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, rf_O1, rf_O2,
      output cmd_ready, busy, rsp_valid, rsp_data,
      output rf_I, rf_FunSel, rf_RSel, rf_TSel, rf_O1Sel, rf_O2Sel
   );
endinterface

// File: rtl/regfile_cmd_sequencer.sv
// Expands one register-transfer command (CLR/LDI/INC/DEC/MOV/SWAP/READ) into
// the multi-cycle control sequence for the 4xR/4xT register file.
module regfile_cmd_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   regfile_cmd_sequencer_if.slave  io_bus
);

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_CLR  = 3'd1;
   localparam logic [2:0] OP_LDI  = 3'd2;
   localparam logic [2:0] OP_INC  = 3'd3;
   localparam logic [2:0] OP_DEC  = 3'd4;
   localparam logic [2:0] OP_MOV  = 3'd5;
   localparam logic [2:0] OP_SWAP = 3'd6;
   localparam logic [2:0] OP_READ = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_RSEL, S_RCAP, S_WA, S_WB, S_RSP
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [2:0]       r_op;
   logic [2:0]       r_dst;
   logic [2:0]       r_src;
   logic [WIDTH-1:0] r_imm;
   logic [WIDTH-1:0] r_hold_a;
   logic [WIDTH-1:0] r_hold_b;
   logic [WIDTH-1:0] r_rsp_data;

   logic             w_cmd_ready;
   logic             w_accept;
   logic [3:0]       w_rsel;
   logic [3:0]       w_tsel;
   logic [1:0]       w_funsel;
   logic [WIDTH-1:0] w_rf_i;
   logic [2:0]       w_o1sel;
   logic [2:0]       w_o2sel;

   // Codes 0..3 are T1..T4 (TSel bit 3..0), codes 4..7 are R1..R4 (RSel bit 3..0).
   function automatic logic [3:0] f_tsel(input logic [2:0] c);
      f_tsel = '0;
      if (!c[2]) f_tsel[2'd3 - c[1:0]] = 1'b1;
   endfunction

   function automatic logic [3:0] f_rsel(input logic [2:0] c);
      f_rsel = '0;
      if (c[2]) f_rsel[2'd3 - c[1:0]] = 1'b1;
   endfunction

   assign w_cmd_ready = (r_state == S_IDLE) && i_rst_n;
   assign w_accept    = io_bus.cmd_valid && w_cmd_ready;

   always_comb begin
      w_state_next = r_state;
      w_rsel       = '0;
      w_tsel       = '0;
      w_funsel     = 2'b00;
      w_rf_i       = '0;
      w_o1sel      = '0;
      w_o2sel      = '0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (io_bus.cmd_op)
                  OP_CLR, OP_LDI, OP_INC, OP_DEC: w_state_next = S_WR;
                  OP_MOV, OP_SWAP, OP_READ:       w_state_next = S_RSEL;
                  default:                        w_state_next = S_IDLE;
               endcase
            end
         end
         S_WR: begin
            w_rsel = f_rsel(r_dst);
            w_tsel = f_tsel(r_dst);
            w_rf_i = (r_op == OP_LDI) ? r_imm : '0;
            case (r_op)
               OP_LDI:  w_funsel = 2'b01;
               OP_DEC:  w_funsel = 2'b10;
               OP_INC:  w_funsel = 2'b11;
               default: w_funsel = 2'b00;
            endcase
            w_state_next = S_IDLE;
         end
         S_RSEL: begin
            w_o1sel      = r_src;
            w_o2sel      = r_dst;
            w_state_next = S_RCAP;
         end
         S_RCAP: begin
            w_o1sel      = r_src;
            w_o2sel      = r_dst;
            w_state_next = (r_op == OP_READ) ? S_RSP : S_WA;
         end
         S_WA: begin
            w_funsel     = 2'b01;
            w_rf_i       = r_hold_a;
            w_rsel       = f_rsel(r_dst);
            w_tsel       = f_tsel(r_dst);
            w_state_next = (r_op == OP_SWAP) ? S_WB : S_IDLE;
         end
         S_WB: begin
            w_funsel     = 2'b01;
            w_rf_i       = r_hold_b;
            w_rsel       = f_rsel(r_src);
            w_tsel       = f_tsel(r_src);
            w_state_next = S_IDLE;
         end
         S_RSP:   w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_op       <= OP_NOP;
         r_dst      <= '0;
         r_src      <= '0;
         r_imm      <= '0;
         r_hold_a   <= '0;
         r_hold_b   <= '0;
         r_rsp_data <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_op  <= io_bus.cmd_op;
            r_dst <= io_bus.cmd_dst;
            r_src <= io_bus.cmd_src;
            r_imm <= io_bus.cmd_imm;
         end
         // Response data is loaded together with hold_a so it is already valid during the RSP pulse.
         if (r_state == S_RCAP) begin
            r_hold_a <= io_bus.rf_O1;
            r_hold_b <= io_bus.rf_O2;
            if (r_op == OP_READ) r_rsp_data <= io_bus.rf_O1;
         end
      end
   end

   assign io_bus.cmd_ready = w_cmd_ready;
   assign io_bus.busy      = ~w_cmd_ready;
   assign io_bus.rsp_valid = (r_state == S_RSP);
   assign io_bus.rsp_data  = r_rsp_data;
   assign io_bus.rf_I      = w_rf_i;
   assign io_bus.rf_FunSel = w_funsel;
   assign io_bus.rf_RSel   = w_rsel;
   assign io_bus.rf_TSel   = w_tsel;
   assign io_bus.rf_O1Sel  = w_o1sel;
   assign io_bus.rf_O2Sel  = w_o2sel;

endmodule

// File: tb/tb_regfile_cmd_sequencer.sv
// Bench: behavioural register file on the rf bus, reference register model and
// a READ-response scoreboard, plus directed cycle checks of the control sequence.
module tb_regfile_cmd_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   acc_cyc = 0;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;
   exp_t sb_q[$];

   logic [7:0] rf_mem [8] = '{default: 8'h00};
   logic [7:0] mdl [8]    = '{default: 8'h00};

   regfile_cmd_sequencer_if #(.WIDTH(8)) ifc ();

   regfile_cmd_sequencer #(.WIDTH(8)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (ifc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Register file: registered read ports, one write per enabled register.
   always @(posedge clk) begin
      ifc.rf_O1 <= rf_mem[ifc.rf_O1Sel];
      ifc.rf_O2 <= rf_mem[ifc.rf_O2Sel];
      for (int c = 0; c < 8; c++) begin
         if ((c < 4) ? ifc.rf_TSel[3-c] : ifc.rf_RSel[7-c]) begin
            case (ifc.rf_FunSel)
               2'b00: rf_mem[c] <= 8'h00;
               2'b01: rf_mem[c] <= ifc.rf_I;
               2'b10: rf_mem[c] <= rf_mem[c] - 8'd1;
               2'b11: rf_mem[c] <= rf_mem[c] + 8'd1;
            endcase
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n) begin
         if (ifc.rsp_valid) begin
            if (sb_q.size() == 0) begin
               chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("rsp_data", {24'd0, ifc.rsp_data}, {24'd0, e.data});
               chk("rsp_latency", cyc, e.cyc);
               $display("[TB] READ rsp data=0x%02h cyc=%0d", ifc.rsp_data, cyc);
            end
         end
         if ((ifc.rf_RSel | ifc.rf_TSel) != 4'd0)
            chk("wr_onehot", $countones({ifc.rf_RSel, ifc.rf_TSel}), 1);
      end
   end

   task automatic apply_model(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                              input logic [7:0] imm);
      logic [7:0] t;
      case (op)
         3'd1: mdl[dst] = 8'h00;
         3'd2: mdl[dst] = imm;
         3'd3: mdl[dst] = mdl[dst] + 8'd1;
         3'd4: mdl[dst] = mdl[dst] - 8'd1;
         3'd5: mdl[dst] = mdl[src];
         3'd6: begin t = mdl[dst]; mdl[dst] = mdl[src]; mdl[src] = t; end
         3'd7: sb_q.push_back('{data: mdl[src], cyc: acc_cyc + 2});
         default: ;
      endcase
   endtask

   task automatic issue(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                        input logic [7:0] imm);
      int n;
      n = 0;
      @(negedge clk);
      while (!ifc.cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", {31'd0, ifc.cmd_ready}, 32'd1);
      ifc.cmd_valid = 1'b1;
      ifc.cmd_op    = op;
      ifc.cmd_dst   = dst;
      ifc.cmd_src   = src;
      ifc.cmd_imm   = imm;
      @(posedge clk);
      #1;
      acc_cyc       = cyc;
      ifc.cmd_valid = 1'b0;
      $display("[TB] cmd op=%0d dst=%0d src=%0d imm=0x%02h accepted cyc=%0d", op, dst, src, imm, cyc);
      apply_model(op, dst, src, imm);
   endtask

   initial begin
      int w;
      rst_n         = 1'b0;
      ifc.cmd_valid = 1'b0;
      ifc.cmd_op    = 3'd0;
      ifc.cmd_dst   = 3'd0;
      ifc.cmd_src   = 3'd0;
      ifc.cmd_imm   = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, ifc.cmd_ready}, 32'd0);
      chk("rst_busy", {31'd0, ifc.busy}, 32'd1);
      chk("rst_rsp_valid", {31'd0, ifc.rsp_valid}, 32'd0);
      chk("rst_rsp_data", {24'd0, ifc.rsp_data}, 32'd0);
      chk("rst_sel", {ifc.rf_RSel, ifc.rf_TSel, ifc.rf_FunSel, ifc.rf_O1Sel, ifc.rf_O2Sel}, 32'd0);
      chk("rst_I", {24'd0, ifc.rf_I}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", {31'd0, ifc.cmd_ready}, 32'd1);

      // LDI R1 then READ R1
      issue(3'd2, 3'd4, 3'd0, 8'h5A);
      @(negedge clk);
      chk("t1_wr", {ifc.rf_RSel, ifc.rf_TSel, 6'd0, ifc.rf_FunSel}, {4'b1000, 4'b0000, 6'd0, 2'b01});
      chk("t1_I", {24'd0, ifc.rf_I}, 32'h5A);
      @(negedge clk);
      chk("t1_ready", {31'd0, ifc.cmd_ready}, 32'd1);
      issue(3'd7, 3'd0, 3'd4, 8'h00);

      // wrap-around on T2
      issue(3'd2, 3'd1, 3'd0, 8'hFF);
      issue(3'd3, 3'd1, 3'd0, 8'h00);
      issue(3'd7, 3'd0, 3'd1, 8'h00);
      issue(3'd4, 3'd1, 3'd0, 8'h00);
      issue(3'd7, 3'd0, 3'd1, 8'h00);

      // SWAP R2 <-> T4
      issue(3'd2, 3'd5, 3'd0, 8'h11);
      issue(3'd2, 3'd3, 3'd0, 8'h22);
      issue(3'd6, 3'd3, 3'd5, 8'h00);
      @(negedge clk);
      chk("t3_rsel_sel", {26'd0, ifc.rf_O1Sel, ifc.rf_O2Sel}, {26'd0, 3'd5, 3'd3});
      chk("t3_rsel_en", {ifc.rf_RSel, ifc.rf_TSel}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("t3_wa", {ifc.rf_RSel, ifc.rf_TSel, ifc.rf_I, ifc.rf_FunSel}, {4'b0000, 4'b0001, 8'h11, 2'b01});
      @(negedge clk);
      chk("t3_wb", {ifc.rf_RSel, ifc.rf_TSel, ifc.rf_I, ifc.rf_FunSel}, {4'b0100, 4'b0000, 8'h22, 2'b01});
      issue(3'd7, 3'd0, 3'd5, 8'h00);
      issue(3'd7, 3'd0, 3'd3, 8'h00);

      // MOV T1 -> R4, busy exactly three cycles
      issue(3'd2, 3'd0, 3'd0, 8'h3C);
      issue(3'd5, 3'd7, 3'd0, 8'h00);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("t4_busy%0d", k), {31'd0, ifc.busy}, (k < 3) ? 32'd1 : 32'd0);
      end
      issue(3'd7, 3'd0, 3'd7, 8'h00);
      issue(3'd7, 3'd0, 3'd0, 8'h00);

      // reset during the capture cycle of a SWAP
      issue(3'd2, 3'd4, 3'd0, 8'hA1);
      issue(3'd2, 3'd7, 3'd0, 8'hB4);
      issue(3'd7, 3'd0, 3'd7, 8'h00);
      w = 0;
      @(negedge clk);
      while (!ifc.cmd_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      ifc.cmd_valid = 1'b1;
      ifc.cmd_op    = 3'd6;
      ifc.cmd_dst   = 3'd7;
      ifc.cmd_src   = 3'd4;
      @(posedge clk);
      #1;
      ifc.cmd_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_en", {ifc.rf_RSel, ifc.rf_TSel}, 32'd0);
      chk("t5_rsp_valid", {31'd0, ifc.rsp_valid}, 32'd0);
      chk("t5_ready_low", {31'd0, ifc.cmd_ready}, 32'd0);
      chk("t5_rsp_data", {24'd0, ifc.rsp_data}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_ready", {31'd0, ifc.cmd_ready}, 32'd1);
      chk("t5_idle_en", {ifc.rf_RSel, ifc.rf_TSel}, 32'd0);
      issue(3'd7, 3'd0, 3'd4, 8'h00);
      issue(3'd7, 3'd0, 3'd7, 8'h00);

      // command held while busy: changes ignored, accepted only in IDLE
      issue(3'd2, 3'd6, 3'd0, 8'h99);
      issue(3'd5, 3'd7, 3'd0, 8'h00);
      ifc.cmd_valid = 1'b1;
      ifc.cmd_op    = 3'd1;
      ifc.cmd_dst   = 3'd6;
      ifc.cmd_src   = 3'd1;
      ifc.cmd_imm   = 8'h77;
      @(negedge clk);
      chk("t6_src_kept", {29'd0, ifc.rf_O1Sel}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("t6_wa_dst", {ifc.rf_RSel, ifc.rf_TSel, ifc.rf_I}, {4'b0001, 4'b0000, mdl[7]});
      @(negedge clk);
      chk("t6_idle", {31'd0, ifc.cmd_ready}, 32'd1);
      @(negedge clk);
      chk("t6_clr", {ifc.rf_RSel, ifc.rf_TSel, ifc.rf_FunSel}, {4'b0010, 4'b0000, 2'b00});
      ifc.cmd_valid = 1'b0;
      mdl[6] = 8'h00;
      @(negedge clk);
      chk("t6_clr_done", {ifc.rf_RSel, ifc.rf_TSel, 7'd0, ifc.cmd_ready}, 32'd1);
      issue(3'd0, 3'd5, 3'd2, 8'h00);
      @(negedge clk);
      chk("t6_nop_busy", {31'd0, ifc.busy}, 32'd0);
      issue(3'd7, 3'd0, 3'd6, 8'h00);

      // random command mix checked through the scoreboard
      for (int i = 0; i < 60; i++) begin
         issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               8'($urandom_range(0, 255)));
      end
      for (int c = 0; c < 8; c++) issue(3'd7, 3'd0, 3'(c), 8'h00);

      w = 0;
      while (sb_q.size() != 0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("sb_drain", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
